// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port round-robin arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int unsigned STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_rr_ptr, mod N.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    logic [IW-1:0] k;
    logic          found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IW'((32'(i_rr_ptr) + i) % N);
      if (!found && i_req[k]) begin
        found      = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = k;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters, burst-limited.
// Optional statistics outputs enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N-1:0]     i_req,
  input  logic [WIDTH-1:0] i_data [N],
  input  logic [N-1:0]     i_last,
  output logic [N-1:0]     o_ready,
  input  logic             i_full,
  output logic             o_wr_en,
  output logic [WIDTH-1:0] o_wr_data,
  output logic [N-1:0]     o_grant,
  output logic             o_busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] o_beat_cnt [N],
  output logic [STAT_W-1:0] o_stall_cnt
`endif
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  arb_state_t     state_q;
  logic [N-1:0]   grant_q;
  logic [IW-1:0]  gidx_q;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

  logic [N-1:0]   pick_grant;
  logic [IW-1:0]  pick_idx;
  logic           busy, req_g, last_g, xfer, at_limit, release_burst;

  rr_pick #(.N(N)) u_pick (
    .i_req    (i_req),
    .i_rr_ptr (rr_ptr_q),
    .o_grant  (pick_grant),
    .o_idx    (pick_idx)
  );

  always_comb begin
    busy          = (state_q == ARB_BURST);
    req_g         = i_req[gidx_q];
    last_g        = i_last[gidx_q];
    xfer          = busy & req_g & ~i_full;
    at_limit      = (beat_cnt_q == BCW'(MAX_BURST - 1));
    // An abandoned grant (req dropped) releases even while the FIFO is full.
    release_burst = busy & (~req_g | (xfer & (last_g | at_limit)));
    rr_ptr_d      = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
    beat_cnt_d    = xfer ? beat_cnt_q + BCW'(1) : beat_cnt_q;
  end

  assign o_ready   = (busy & ~i_full) ? grant_q : '0;
  assign o_wr_en   = xfer;
  assign o_wr_data = i_data[gidx_q];
  assign o_grant   = grant_q;
  assign o_busy    = busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|i_req) begin
            state_q    <= ARB_BURST;
            grant_q    <= pick_grant;
            gidx_q     <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        ARB_BURST: begin
          if (release_burst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= rr_ptr_d;
          end else begin
            beat_cnt_q <= beat_cnt_d;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] beat_stat_q [N];
  logic [STAT_W-1:0] stall_q;

  for (genvar k = 0; k < N; k++) begin : g_beat_stat
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        beat_stat_q[k] <= '0;
      end else if (xfer && gidx_q == IW'(k)) begin
        beat_stat_q[k] <= sat_inc(beat_stat_q[k]);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_q <= '0;
    end else if (busy && i_full && req_g) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign o_beat_cnt  = beat_stat_q;
  assign o_stall_cnt = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
